// File: rtl/timer_int.sv
// timer_int: programmable 8-bit interval timer on the CPU port bus.
// Five byte registers at BASE..BASE+4 (CTRL, PRESCALE, RELOAD, STATUS, COUNT).
// A prescaler divides the clock, each prescaler wrap is one tick, and the
// down-counter raises a sticky flag when a tick finds it at zero. The flag,
// gated by CTRL.ie, is the interrupt request.
module timer_int #(
   parameter logic [3:0] BASE = 4'hA
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [3:0] addr,
   input  logic [7:0] wdata,
   input  logic       iret,
   output logic [7:0] rdata,
   output logic       sel,
   output logic       int_req
);

   // Register offsets relative to BASE
   localparam logic [3:0] OFF_CTRL   = 4'd0;
   localparam logic [3:0] OFF_PRESC  = 4'd1;
   localparam logic [3:0] OFF_RELOAD = 4'd2;
   localparam logic [3:0] OFF_STATUS = 4'd3;
   localparam logic [3:0] OFF_COUNT  = 4'd4;

   // Architectural state
   logic       en_q,   en_d;
   logic       auto_q, auto_d;
   logic       ie_q,   ie_d;
   logic       flag_q, flag_d;
   logic [7:0] prescale_q, prescale_d;
   logic [7:0] reload_q,   reload_d;
   logic [7:0] count_q,    count_d;
   logic [7:0] pcnt_q,     pcnt_d;

   // Decode and event strobes
   logic [3:0] off;
   logic       wr;
   logic       ctrl_wr;
   logic       start;
   logic       stop;
   logic       tick;
   logic       expire;
   logic       flag_clr;

   // Offset arithmetic wraps modulo 16, so BASE-1 maps to 4'hF and is rejected
   assign off = addr - BASE;
   assign sel = (off <= OFF_COUNT);
   assign wr  = we & sel;

   // Bus events and timebase events, all derived from registered state
   always_comb begin
      ctrl_wr  = wr && (off == OFF_CTRL);
      start    = ctrl_wr && wdata[0] && !en_q;
      stop     = ctrl_wr && !wdata[0] && en_q;
      tick     = en_q && (pcnt_q == prescale_q);
      expire   = tick && (count_q == 8'd0);
      flag_clr = iret || (wr && (off == OFF_STATUS) && wdata[0]);
   end

   // CTRL bits: start/stop from the bus, one-shot auto-clear of en on expiry;
   // an explicit stop write and the one-shot clear both drive en to 0
   always_comb begin
      auto_d = auto_q;
      ie_d   = ie_q;
      en_d   = en_q;
      if (ctrl_wr) begin
         auto_d = wdata[1];
         ie_d   = wdata[2];
      end
      if (start) begin
         en_d = 1'b1;
      end else if (stop) begin
         en_d = 1'b0;
      end else if (expire && !auto_q) begin
         en_d = 1'b0;
      end
   end

   // PRESCALE and RELOAD are plain byte registers; a new RELOAD is only
   // consumed at the next start or auto-reload, a new PRESCALE at once
   always_comb begin
      prescale_d = prescale_q;
      reload_d   = reload_q;
      if (wr && (off == OFF_PRESC)) begin
         prescale_d = wdata;
      end
      if (wr && (off == OFF_RELOAD)) begin
         reload_d = wdata;
      end
   end

   // Prescaler: restarts from 0 on start and stop, otherwise free-runs while
   // enabled and wraps on the cycle it matches PRESCALE. If PRESCALE is lowered
   // below the current value it wraps through 255 before the next tick.
   always_comb begin
      pcnt_d = pcnt_q;
      if (start || stop) begin
         pcnt_d = 8'd0;
      end else if (en_q) begin
         pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
      end
   end

   // Down-counter: loaded on start, decremented per tick, reloaded on expiry in
   // auto mode, held at 0 after a one-shot expiry; never decrements below 0
   always_comb begin
      count_d = count_q;
      if (start) begin
         count_d = reload_q;
      end else if (tick) begin
         if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
         end else if (auto_q) begin
            count_d = reload_q;
         end
      end
   end

   // Expiry flag: a set in the same cycle as a clear wins
   always_comb begin
      flag_d = flag_q;
      if (flag_clr) begin
         flag_d = 1'b0;
      end
      if (expire) begin
         flag_d = 1'b1;
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q       <= 1'b0;
         auto_q     <= 1'b0;
         ie_q       <= 1'b0;
         flag_q     <= 1'b0;
         prescale_q <= 8'd0;
         reload_q   <= 8'd0;
         count_q    <= 8'd0;
         pcnt_q     <= 8'd0;
      end else begin
         en_q       <= en_d;
         auto_q     <= auto_d;
         ie_q       <= ie_d;
         flag_q     <= flag_d;
         prescale_q <= prescale_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
         pcnt_q     <= pcnt_d;
      end
   end

   // Zero-latency read mux; reads have no side effects
   always_comb begin
      rdata = 8'd0;
      if (sel) begin
         case (off)
            OFF_CTRL:   rdata = {5'd0, ie_q, auto_q, en_q};
            OFF_PRESC:  rdata = prescale_q;
            OFF_RELOAD: rdata = reload_q;
            OFF_STATUS: rdata = {7'd0, flag_q};
            OFF_COUNT:  rdata = count_q;
            default:    rdata = 8'd0;
         endcase
      end
   end

   // Interrupt request built only from registered bits
   assign int_req = flag_q & ie_q;

endmodule

// File: tb/tb_timer_int.sv
// tb_timer_int: directed test-plan scenarios with fixed expectations, then a
// randomized bus/iret phase compared cycle by cycle with a behavioural model.
module tb_timer_int;

   localparam logic [3:0] BASE = 4'hA;

   logic       clk;
   logic       reset;
   logic       we;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic       iret;
   logic [7:0] rdata;
   logic       sel;
   logic       int_req;

   int checks = 0;
   int errors = 0;

   timer_int #(.BASE(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .iret    (iret),
      .rdata   (rdata),
      .sel     (sel),
      .int_req (int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the programmer-visible state
   typedef struct {
      bit       en;
      bit       rep;
      bit       ie;
      bit       flag;
      bit [7:0] pre;
      bit [7:0] rel;
      bit [7:0] count;
      bit [7:0] pcnt;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_reset_state();
      mstate_t s;
      s.en = 0; s.rep = 0; s.ie = 0; s.flag = 0;
      s.pre = 0; s.rel = 0; s.count = 0; s.pcnt = 0;
      return s;
   endfunction

   // One clock edge of the timer, applying the rules in order:
   // timebase tick, bus write, then flag clear/set (set wins)
   function automatic mstate_t model_next(mstate_t s, bit w, logic [3:0] a,
                                          logic [7:0] d, bit ir);
      mstate_t n = s;
      bit       fired = s.en && (s.pcnt == s.pre);
      bit       expired = fired && (s.count == 0);
      bit [3:0] o = a - BASE;
      bit       hit = w && (o <= 4);
      if (s.en) n.pcnt = fired ? 8'd0 : s.pcnt + 8'd1;
      if (fired) begin
         if (s.count != 0) n.count = s.count - 1;
         else if (s.rep) n.count = s.rel;
         else n.en = 0;
      end
      if (hit) begin
         case (o)
            4'd0: begin
               n.rep = d[1];
               n.ie  = d[2];
               if (d[0] && !s.en) begin
                  n.en = 1; n.count = s.rel; n.pcnt = 0;
               end else if (!d[0] && s.en) begin
                  n.en = 0; n.pcnt = 0;
               end
            end
            4'd1: n.pre = d;
            4'd2: n.rel = d;
            default: ;
         endcase
      end
      if (ir || (hit && o == 4'd3 && d[0])) n.flag = 0;
      if (expired) n.flag = 1;
      return n;
   endfunction

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge; inputs return to idle 1 ns later
   task automatic step();
      @(posedge clk);
      if (!reset) m = model_reset_state();
      else m = model_next(m, we, addr, wdata, iret);
      #1;
      we   = 1'b0;
      iret = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; wdata = d;
      $display("WR addr=%h data=%h t=%0t", a, d, $time);
      step();
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   // Compare all five registers and int_req against the model
   task automatic check_model(input string tag);
      logic [7:0] v;
      rd(BASE + 4'd0, v); check_eq({tag, "_ctrl"},   v, {5'd0, m.ie, m.rep, m.en});
      rd(BASE + 4'd1, v); check_eq({tag, "_presc"},  v, m.pre);
      rd(BASE + 4'd2, v); check_eq({tag, "_reload"}, v, m.rel);
      rd(BASE + 4'd3, v); check_eq({tag, "_status"}, v, {7'd0, m.flag});
      rd(BASE + 4'd4, v); check_eq({tag, "_count"},  v, m.count);
      check_eq({tag, "_intreq"}, int_req, m.flag && m.ie);
   endtask

   task automatic check_zero(input string tag);
      logic [7:0] v;
      for (int i = 0; i < 5; i++) begin
         rd(BASE + 4'(i), v);
         check_eq($sformatf("%s_reg%0d", tag, i), v, 0);
      end
      check_eq({tag, "_intreq"}, int_req, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m = model_reset_state();
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic periodic_setup();
      wr(BASE + 4'd1, 8'd3);
      wr(BASE + 4'd2, 8'd4);
      wr(BASE + 4'd0, 8'h07);
   endtask

   initial begin
      logic [7:0] v;
      logic [3:0] ra;
      logic [7:0] rdv;
      reset = 1'b0; we = 1'b0; iret = 1'b0; addr = '0; wdata = '0;
      m = model_reset_state();
      #1;
      step(); step(); step();
      reset = 1'b1;
      check_zero("reset");

      // Periodic: flag at E0+20, iret at E0+22, flag again at E0+40
      periodic_setup();
      for (int k = 1; k <= 40; k++) begin
         if (k == 22) iret = 1'b1;
         step();
         if (k == 19) check_eq("per_pre_expiry", int_req, 0);
         if (k == 20) begin
            check_eq("per_expiry", int_req, 1);
            rd(BASE + 4'd4, v); check_eq("per_count_reload", v, 4);
         end
         if (k == 21) check_eq("per_held", int_req, 1);
         if (k == 22) check_eq("per_iret_clear", int_req, 0);
         if (k == 39) check_eq("per_pre_second", int_req, 0);
         if (k == 40) check_eq("per_second", int_req, 1);
      end

      // One-shot: flag at E0+3, en auto-cleared, COUNT parked at 0
      do_reset();
      wr(BASE + 4'd1, 8'd0);
      wr(BASE + 4'd2, 8'd2);
      wr(BASE + 4'd0, 8'h05);
      step(); step();
      rd(BASE + 4'd3, v); check_eq("os_pre_flag", v, 0);
      step();
      rd(BASE + 4'd3, v); check_eq("os_flag", v, 1);
      rd(BASE + 4'd0, v); check_eq("os_ctrl", v, 8'h04);
      repeat (20) step();
      rd(BASE + 4'd4, v); check_eq("os_count_parked", v, 0);
      check_eq("os_intreq", int_req, 1);

      // Simultaneous iret on the expiry edge: set wins
      do_reset();
      periodic_setup();
      for (int k = 1; k <= 20; k++) begin
         if (k == 20) iret = 1'b1;
         step();
      end
      rd(BASE + 4'd3, v); check_eq("sim_flag", v, 1);
      check_eq("sim_intreq", int_req, 1);

      // Masked: flag visible in STATUS, no request; write 0 keeps, write 1 clears
      do_reset();
      wr(BASE + 4'd1, 8'd0);
      wr(BASE + 4'd2, 8'd5);
      wr(BASE + 4'd0, 8'h03);
      repeat (6) step();
      rd(BASE + 4'd3, v); check_eq("mask_status", v, 8'h01);
      check_eq("mask_intreq", int_req, 0);
      wr(BASE + 4'd3, 8'h00);
      rd(BASE + 4'd3, v); check_eq("mask_write0", v, 8'h01);
      wr(BASE + 4'd3, 8'h01);
      rd(BASE + 4'd3, v); check_eq("mask_write1", v, 8'h00);

      // Reset mid-count aborts immediately and nothing fires afterwards
      do_reset();
      periodic_setup();
      repeat (9) step();
      reset = 1'b0;
      m = model_reset_state();
      check_zero("arst_async");
      step();
      reset = 1'b1;
      begin
         int seen = 0;
         for (int k = 0; k < 100; k++) begin
            step();
            if (int_req) seen++;
         end
         check_eq("arst_no_intreq", seen, 0);
      end
      check_zero("arst_after");

      // Decode window and ignored writes
      do_reset();
      wr(BASE + 4'd1, 8'h5A);
      wr(BASE + 4'd2, 8'h33);
      addr = BASE + 4'd5; #1;
      check_eq("dec_hi_sel", sel, 0);
      check_eq("dec_hi_rdata", rdata, 0);
      addr = BASE - 4'd1; #1;
      check_eq("dec_lo_sel", sel, 0);
      check_eq("dec_lo_rdata", rdata, 0);
      addr = BASE; #1;
      check_eq("dec_base_sel", sel, 1);
      addr = BASE + 4'd4; #1;
      check_eq("dec_top_sel", sel, 1);
      wr(BASE + 4'd5, 8'hFF);
      wr(BASE - 4'd1, 8'h07);
      wr(BASE + 4'd4, 8'h77);
      check_model("dec_after");
      rd(BASE + 4'd1, v); check_eq("dec_presc_kept", v, 8'h5A);
      rd(BASE + 4'd4, v); check_eq("dec_count_ro", v, 0);

      // Randomized bus traffic and iret pulses against the model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 99) < 22) begin
            ra = 4'(BASE - 4'd1 + 4'($urandom_range(0, 6)));
            case (4'(ra - BASE))
               4'd1:    rdv = 8'($urandom_range(0, 3));
               4'd2:    rdv = 8'($urandom_range(0, 9));
               default: rdv = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) iret = 1'b1;
            wr(ra, rdv);
         end else begin
            if ($urandom_range(0, 15) == 0) iret = 1'b1;
            step();
         end
         check_model("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_int.md
# timer_int

Programmable 8-bit interval timer on the CPU port bus; it raises the interrupt request consumed by the I/O block, which forwards it to the control unit as `g_int`. The CPU configures the timer with port-write instructions, reads count and status back through port reads, and retires the request with `iret`. The block adds a periodic time source so interrupt handling can be exercised without driving external pins.

## Interface
- `BASE`, default 4'hA: first port address; the block decodes BASE..BASE+4.
- `clk` input 1: system clock; every register updates on its rising edge.
- `reset` input 1: asynchronous reset, active-low.
- `we` input 1: port write strobe, one cycle per write instruction.
- `addr` input 4: port address from the datapath.
- `wdata` input 8: data written to the port.
- `iret` input 1: interrupt-return pulse from the control unit; clears the expiry flag.
- `rdata` output 8: combinational read data for `addr`; 0 when `sel`=0.
- `sel` output 1: combinational; 1 when `addr` is in BASE..BASE+4.
- `int_req` output 1: interrupt request, equal to `flag & CTRL[2]`, driven only from registered bits.

## Operation
- Register map, with offsets relative to BASE:
  - +0 CTRL: r/w. bit0 `en`, bit1 `auto`, bit2 `ie`, bits 7:3 read as 0.
  - +1 PRESCALE: r/w.
  - +2 RELOAD: r/w.
  - +3 STATUS: bit0 `flag`. Writing 1 to bit0 clears it; writing 0 has no effect.
  - +4 COUNT: read-only. Writes are ignored.
- Writes take effect only when `we`=1 and `sel`=1.
- Internal state:
  - 8-bit prescaler counter `pcnt`.
  - 8-bit `count`.
  - Register bits `en`, `auto`, `ie`, `flag`.
- Start: a CTRL write that sets `en` while `en` is 0 loads `count` with RELOAD and clears `pcnt`.
  - A CTRL write with `en` already 1 updates only `auto` and `ie`. It does not restart the count.
- Stop: a CTRL write that clears `en` freezes `count` and clears `pcnt`.
- Tick: while `en`=1, `pcnt` increments each cycle. When `pcnt`==PRESCALE, `pcnt` wraps to 0 and one tick occurs.
  - PRESCALE=0 gives one tick every cycle.
- On each tick:
  - If `count`≠0: `count` ← `count`−1.
  - If `count`==0: `flag` ← 1. Then, if `auto`=1, `count` ← RELOAD; if `auto`=0, `en` ← 0 (one-shot).
- Period from the enabling edge to the `flag` edge is (RELOAD+1)·(PRESCALE+1) cycles.
- Writing RELOAD or PRESCALE while running:
  - A new RELOAD applies only at the next reload.
  - A new PRESCALE applies immediately. If `pcnt` > new PRESCALE, `pcnt` counts up and wraps through 255 before the next tick; this is acceptable and documented.
- `flag` is cleared by an `iret` pulse or by a STATUS write with bit0=1.
- Priority rules:
  - If `flag` is set and cleared in the same cycle, set wins.
  - A CTRL write that clears `en` has priority over the one-shot auto-clear of `en` in the same cycle.
- Arithmetic is all 8-bit unsigned. There is no decrement below 0.

## Timing
- Reset (`reset`=0, asynchronous) drives to 0: CTRL, PRESCALE, RELOAD, `flag`, `count`, `pcnt`.
  - Consequently `int_req`=0 and `rdata`=0 for any in-range address.
- Reset asserted mid-count aborts immediately. No flag is produced after release.
- Write latency: register value is visible on `rdata` the cycle after the write edge.
- `flag` and `int_req` rise on the same clock edge as the expiring tick. `int_req` is not delayed further.
- `int_req` falls on the edge that samples `iret`=1 or the STATUS clear write.
- Reads have zero latency and no side effects; reading STATUS does not clear it.

## Test plan
- Periodic: PRESCALE=3, RELOAD=4, CTRL=0x07 written at edge E0 → `int_req` rises at E0+20.
  - Pulse `iret` at E0+22 → `int_req` low at E0+22, high again at E0+40. COUNT reads 4 at E0+20.
- One-shot: PRESCALE=0, RELOAD=2, CTRL=0x05 at E0 → `flag` rises at E0+3. CTRL then reads 0x04 and COUNT stays 0 indefinitely.
- Simultaneous: arrange `iret` on the exact expiry edge → `flag` stays 1 and `int_req` stays 1.
- Masked: CTRL=0x03 → STATUS reads 0x01 after expiry while `int_req` stays 0. Writing 0x01 to STATUS → reads 0x00.
- Reset mid-count: pulse `reset` low at E0+10 of the periodic setup → all registers read 0 and there is no `int_req` for the following 100 cycles.
- Decode: `addr`=BASE+5 and `addr`=BASE−1 → `sel`=0 and `rdata`=0. A write to `addr`=BASE+5 changes no register. A write to COUNT is ignored.
